// File: rtl/secure_lsu.sv
// Secured load/store unit: scrambles store data, unscrambles load data, guards a protected window.
// Latency: accept at T -> mem_req at T+1, ack at T+1+n -> resp_valid at T+2+n; lock fault -> T+1.
// Backpressure: one transaction in flight, req_ready low until the response is taken; no queueing.
module secure_lsu #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]  PROT_BASE  = 10'h3C0,
  parameter logic [ADDR_W-1:0]  PROT_LIMIT = 10'h3FF,
  parameter logic [DATA_W-1:0]  KEY_RESET  = 32'h0000_0000,
  parameter int                 TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  input  logic              key_we,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              lock,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  // Window span; an offset compare handles a window ending at the top of the address space.
  localparam logic [ADDR_W-1:0] WIN_SPAN = PROT_LIMIT - PROT_BASE;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] txn_key_q, txn_key_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] win_off;
  logic              denied;
  logic              accept;
  logic              timeout_hit;

  assign win_off     = req_addr - PROT_BASE;
  assign denied      = lock && (win_off <= WIN_SPAN);
  assign accept      = (state_q == S_IDLE) && req_valid;
  assign timeout_hit = (state_q == S_MEM) && !mem_ack && (cnt_q == CNT_LAST);

  // State register; reset abandons any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = denied ? S_RESP : S_MEM;
      S_MEM:  if (mem_ack || timeout_hit) state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: request capture, key snapshot, wait counter, response payload.
  always_comb begin
    key_d     = key_we ? key_wdata : key_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txn_key_d = txn_key_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    if (accept) begin
      we_d      = req_we;
      addr_d    = req_addr;
      wdata_d   = req_wdata;
      txn_key_d = key_q;          // old key even if key_we is high this cycle
      cnt_d     = '0;
      rdata_d   = '0;
      fault_d   = denied;
    end else if (state_q == S_MEM) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mem_ack) begin
        rdata_d = we_q ? '0 : (mem_rdata ^ txn_key_q);
        fault_d = 1'b0;
      end else if (timeout_hit) begin
        rdata_d = '0;
        fault_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= KEY_RESET;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txn_key_q <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      key_q     <= key_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txn_key_q <= txn_key_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs decoded from registered state only; zero whenever their phase is inactive.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = 1'b0;
    if (state_q == S_MEM) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q ^ txn_key_q;
    end
    if (state_q == S_RESP) begin
      resp_valid = 1'b1;
      resp_rdata = rdata_q;
      resp_fault = fault_q;
    end
  end

endmodule

// File: tb/tb_secure_lsu.sv
// Directed bench for secure_lsu: per-cycle vector table plus timeout/reset sequences.
// Inputs driven on the falling edge; outputs compared 1ns later.
// Every wait is bounded; a watchdog ends the run if anything stalls.
module tb_secure_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        key_we, lock;
  logic [31:0] key_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  secure_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .key_we(key_we), .key_wdata(key_wdata), .lock(lock),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // {req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_wdata}
  typedef struct {
    string       name;
    logic        rv, we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        rr, kwe;
    logic [31:0] kwd;
    logic        lk;
    logic [31:0] mrd;
    logic        ack;
    logic [78:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [78:0] outs();
    return {req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [78:0] e_idle();
    return {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0};
  endfunction

  function automatic logic [78:0] e_mem(input logic w, input logic [9:0] a, input logic [31:0] d);
    return {1'b0, 1'b0, 32'h0, 1'b0, 1'b1, w, a, d};
  endfunction

  function automatic logic [78:0] e_resp(input logic [31:0] rd, input logic f);
    return {1'b0, 1'b1, rd, f, 1'b0, 1'b0, 10'h0, 32'h0};
  endfunction

  task automatic set_in(input string n, input logic rv, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, input logic rr, input logic kwe,
                        input logic [31:0] kwd, input logic lk, input logic [31:0] mrd,
                        input logic ack);
    cur.name = n; cur.rv = rv; cur.we = we; cur.addr = a; cur.wd = wd; cur.rr = rr;
    cur.kwe = kwe; cur.kwd = kwd; cur.lk = lk; cur.mrd = mrd; cur.ack = ack;
  endtask

  task automatic push(input logic [78:0] e);
    cur.exp = e;
    tbl.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.rv; req_we = v.we; req_addr = v.addr; req_wdata = v.wd;
    resp_ready = v.rr; key_we = v.kwe; key_wdata = v.kwd; lock = v.lk;
    mem_rdata = v.mrd; mem_ack = v.ack;
  endtask

  task automatic idle_in();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
    key_we = 0; key_wdata = '0; lock = 0; mem_rdata = '0; mem_ack = 0;
  endtask

  task automatic check(input string n, input logic [78:0] got, input logic [78:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hi;
    // name, rv, we, addr, wd, rr, kwe, kwd, lk, mrd, ack
    // 1: key load, store with ack on the third MEM cycle
    set_in("t1_key",      0,0,10'h000,32'h0,       0,1,32'hA5A5A5A5,0,32'h0,0); push(e_idle());
    set_in("t1_accept",   1,1,10'h010,32'h12345678,0,0,32'h0,0,32'h0,0);        push(e_idle());
    set_in("t1_mem0",     0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_mem(1,10'h010,32'hB791F3DD));
    set_in("t1_mem1",     0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_mem(1,10'h010,32'hB791F3DD));
    set_in("t1_mem_ack",  0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,1);        push(e_mem(1,10'h010,32'hB791F3DD));
    set_in("t1_resp",     0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,0));
    // 2: load back-to-back, ack in first MEM cycle
    set_in("t2_accept",   1,0,10'h010,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_idle());
    set_in("t2_mem_ack",  0,0,10'h000,32'h0,       0,0,32'h0,0,32'hB791F3DD,1); push(e_mem(0,10'h010,32'hA5A5A5A5));
    set_in("t2_resp",     0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h12345678,0));
    // 3: locked window fault, held response, then unlocked access
    set_in("t3_lk_acc",   1,0,10'h3C5,32'h0,       0,0,32'h0,1,32'h0,0);        push(e_idle());
    set_in("t3_lk_hold",  0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,1));
    set_in("t3_lk_resp",  0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,1));
    set_in("t3_ul_acc",   1,0,10'h3C5,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_idle());
    set_in("t3_ul_mem",   0,0,10'h000,32'h0,       0,0,32'h0,0,32'h6F5B1F1B,1); push(e_mem(0,10'h3C5,32'hA5A5A5A5));
    set_in("t3_ul_resp",  0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'hCAFEBABE,0));
    // window edges under lock: 3BF outside, 3FF and 3C0 inside
    set_in("t3_3bf_acc",  1,1,10'h3BF,32'h0000FFFF,0,0,32'h0,1,32'h0,0);        push(e_idle());
    set_in("t3_3bf_mem",  0,0,10'h000,32'h0,       0,0,32'h0,1,32'h0,1);        push(e_mem(1,10'h3BF,32'hA5A55A5A));
    set_in("t3_3bf_resp", 0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,0));
    set_in("t3_3ff_acc",  1,1,10'h3FF,32'h1,       0,0,32'h0,1,32'h0,0);        push(e_idle());
    set_in("t3_3ff_resp", 0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,1));
    set_in("t3_3c0_acc",  1,0,10'h3C0,32'h0,       0,0,32'h0,1,32'h0,0);        push(e_idle());
    set_in("t3_3c0_resp", 0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,1));
    // 5: key change while in MEM, and key change coincident with accept
    set_in("t5_accept",   1,1,10'h020,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_idle());
    set_in("t5_mem_kwe",  0,0,10'h000,32'h0,       0,1,32'h0F0F0F0F,0,32'h0,0); push(e_mem(1,10'h020,32'hA5A5A5A5));
    set_in("t5_mem1",     0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_mem(1,10'h020,32'hA5A5A5A5));
    set_in("t5_mem_ack",  0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,1);        push(e_mem(1,10'h020,32'hA5A5A5A5));
    set_in("t5_resp",     0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,0));
    set_in("t5_nx_acc",   1,1,10'h021,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_idle());
    set_in("t5_nx_mem",   0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,1);        push(e_mem(1,10'h021,32'h0F0F0F0F));
    set_in("t5_nx_resp",  0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,0));
    set_in("t5_co_acc",   1,1,10'h022,32'h0,       0,1,32'h12341234,0,32'h0,0); push(e_idle());
    set_in("t5_co_mem",   0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,1);        push(e_mem(1,10'h022,32'h0F0F0F0F));
    set_in("t5_co_resp",  0,0,10'h000,32'h0,       1,0,32'h0,0,32'h0,0);        push(e_resp(32'h0,0));
    set_in("t5_idle",     0,0,10'h000,32'h0,       0,0,32'h0,0,32'h0,0);        push(e_idle());

    // reset state
    idle_in();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1 check("reset_state", outs(), e_idle());

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 check(tbl[i].name, outs(), tbl[i].exp);
    end

    // 4: no ack -> mem_req high for exactly 8 cycles, then timeout fault (key is now 12341234)
    @(negedge clk); idle_in(); req_valid = 1; req_we = 1; req_addr = 10'h030; req_wdata = 32'h55;
    @(negedge clk); idle_in(); #1;
    hi = 0;
    for (int c = 0; c < 30 && mem_req === 1'b1; c++) begin
      hi++;
      @(negedge clk); #1;
    end
    check("t4_mreq_cycles", 79'(hi), 79'(8));
    check("t4_timeout_resp", outs(), e_resp(32'h0, 1'b1));
    @(negedge clk); #1 check("t4_resp_stall", outs(), e_resp(32'h0, 1'b1));
    resp_ready = 1;
    @(negedge clk); resp_ready = 0; #1 check("t4_back_idle", outs(), e_idle());

    // ack in the last allowed MEM cycle wins over the timeout
    req_valid = 1; req_we = 0; req_addr = 10'h031;
    @(negedge clk); idle_in();
    repeat (7) @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h0;
    #1 check("t4_last_cycle_mem", outs(), e_mem(1'b0, 10'h031, 32'h12341234));
    @(negedge clk); mem_ack = 0; #1 check("t4_last_cycle_resp", outs(), e_resp(32'h12341234, 1'b0));
    resp_ready = 1;
    @(negedge clk); resp_ready = 0;

    // 6: reset in MEM drops mem_req, no response, key returns to reset value
    req_valid = 1; req_we = 1; req_addr = 10'h040; req_wdata = 32'h1;
    @(negedge clk); idle_in(); #1 check("t6_in_mem", outs(), e_mem(1'b1, 10'h040, 32'h12341235));
    reset = 1;
    @(negedge clk); reset = 0; #1 check("t6_after_reset", outs(), e_idle());
    @(negedge clk); #1 check("t6_no_resp", outs(), e_idle());
    req_valid = 1; req_we = 1; req_addr = 10'h041; req_wdata = 32'hCAFEF00D;
    @(negedge clk); idle_in(); mem_ack = 1; #1 check("t6_key_reset", outs(), e_mem(1'b1, 10'h041, 32'hCAFEF00D));
    @(negedge clk); mem_ack = 0; #1 check("t6_resp", outs(), e_resp(32'h0, 1'b0));
    resp_ready = 1;
    @(negedge clk); resp_ready = 0; #1 check("t6_final_idle", outs(), e_idle());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
